// File: rtl/intr_ctrl.sv
// Memory-mapped priority interrupt controller with nested in-service tracking.
// Source 0 has the highest priority. IRQ/IVEC are registered, and the ISR bits block lower levels.
module intr_ctrl #(
  parameter int               ABITS = 32,
  parameter int               DBITS = 32,
  parameter logic [ABITS-1:0] RBASE = 'hF0000100,
  parameter int               NSRC  = 4
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             LOCK,
  input  logic [ABITS-1:0] ABUS,
  inout  tri   [DBITS-1:0] RBUS,
  input  logic             RE,
  input  logic [DBITS-1:0] WBUS,
  input  logic             WE,
  input  logic [NSRC-1:0]  INTR_IN,
  output logic             IRQ,
  output logic [3:0]       IVEC,
  input  logic             IACK,
  input  logic             IRET
);

  localparam logic [ABITS-1:0] A_PEND = RBASE;
  localparam logic [ABITS-1:0] A_MASK = RBASE + ABITS'(4);
  localparam logic [ABITS-1:0] A_ISR  = RBASE + ABITS'(8);
  localparam logic [ABITS-1:0] A_CTRL = RBASE + ABITS'(12);

  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] isr_q, isr_d;
  logic            gie_q, gie_d;
  logic            irq_q, irq_d;
  logic [3:0]      ivec_q, ivec_d;

  logic [NSRC-1:0] act, elig, top_bit, clr, set;
  logic [4:0]      top;
  logic [3:0]      win;
  logic            top_found, win_found;
  logic [DBITS-1:0] rdata;
  logic            rsel;
  logic            unused_wbus;

  assign unused_wbus = ^WBUS;

  // Arbitration: only active sources above the highest in-service level compete.
  always_comb begin
    act       = INTR_IN & mask_q;
    top       = 5'(NSRC);
    top_bit   = '0;
    top_found = 1'b0;
    elig      = '0;
    win       = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (!top_found && isr_q[i]) begin
        top        = 5'(i);
        top_bit[i] = 1'b1;
        top_found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (act[i] && (5'(i) < top)) elig[i] = 1'b1;
    end
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (!win_found && elig[i]) begin
        win       = 4'(i);
        win_found = 1'b1;
      end
    end
  end

  // ISR: IRET and EOI writes clear; an acknowledged request sets and wins over the clear.
  always_comb begin
    clr = '0;
    set = '0;
    if (IRET) clr = top_bit;
    if (WE && (ABUS == A_ISR)) clr = clr | WBUS[NSRC-1:0];
    if (IACK && irq_q) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (ivec_q == 4'(i)) set[i] = 1'b1;
      end
    end
    isr_d = (isr_q & ~clr) | set;
  end

  always_comb begin
    mask_d = mask_q;
    gie_d  = gie_q;
    irq_d  = 1'b0;
    ivec_d = ivec_q;
    if (WE && (ABUS == A_MASK)) mask_d = WBUS[NSRC-1:0];
    if (WE && (ABUS == A_CTRL)) gie_d = WBUS[0];
    if (!IACK && gie_q && (|elig)) begin
      irq_d  = 1'b1;
      ivec_d = win;
    end
  end

  always_ff @(posedge CLK) begin
    if (LOCK) begin
      if (INIT) begin
        mask_q <= '0;
        isr_q  <= '0;
        gie_q  <= 1'b0;
        irq_q  <= 1'b0;
        ivec_q <= '0;
      end else begin
        mask_q <= mask_d;
        isr_q  <= isr_d;
        gie_q  <= gie_d;
        irq_q  <= irq_d;
        ivec_q <= ivec_d;
      end
    end
  end

  // Reads see the pre-edge state, so a simultaneous write returns the old value.
  always_comb begin
    rdata = '0;
    rsel  = 1'b0;
    if (RE) begin
      if (ABUS == A_PEND) begin
        rdata[NSRC-1:0] = INTR_IN;
        rsel            = 1'b1;
      end else if (ABUS == A_MASK) begin
        rdata[NSRC-1:0] = mask_q;
        rsel            = 1'b1;
      end else if (ABUS == A_ISR) begin
        rdata[NSRC-1:0] = isr_q;
        rsel            = 1'b1;
      end else if (ABUS == A_CTRL) begin
        rdata[0]   = gie_q;
        rdata[1]   = irq_q;
        rdata[7:4] = ivec_q;
        rsel       = 1'b1;
      end
    end
  end

  assign RBUS = rsel ? rdata : 'z;
  assign IRQ  = irq_q;
  assign IVEC = ivec_q;

endmodule
